alu: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_if.sv | 24 ++
 rtl/alu_div.sv | 108 ++++++++++
 rtl/alu.sv | 174 +++++++++++++++++
 tb/tb_alu.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the RV64IM execute-stage ALU: opcodes, func3 values,
// engine FSM states and a small sign-extension helper.
package alu_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int DIV_ITERS = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Execute-stage operand/result bundle between the pipeline (master) and the ALU (slave).
interface alu_if;

    logic [63:0] scr1;
    logic [63:0] scr2;
    logic [63:0] imm;
    logic [2:0]  func3;
    logic        func7;
    logic [6:0]  opcode;
    logic        mul_en;
    logic        stall;
    logic [63:0] result;

    modport master (
        output scr1, scr2, imm, func3, func7, opcode, mul_en,
        input  stall, result
    );

    modport slave (
        input  scr1, scr2, imm, func3, func7, opcode, mul_en,
        output stall, result
    );

endinterface

// File: rtl/alu_div.sv
// Iterative restoring divider: 64 iterations on magnitudes, sign fix-up and
// divide-by-zero / signed-overflow handling applied to the final outputs.
module alu_div
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    localparam logic [6:0] DIV_LAST = 7'(DIV_ITERS);

    logic        busy;
    logic [6:0]  cnt;
    logic [63:0] quo_p1, rem_p1, den_p1, orig_p1;
    logic        neg_q_p1, neg_r_p1, by_zero_p1, ovf_p1;

    logic signed [63:0] a_ext, b_ext;
    logic [63:0]        a_mag, b_mag, min_val;
    logic               a_neg, b_neg;
    logic [64:0]        rem_sh, diff;

    // Word mode widens the low halves first, so the 64-bit core serves both widths.
    always_comb begin
        a_ext   = dividend;
        b_ext   = divisor;
        min_val = 64'h8000_0000_0000_0000;
        if (word) begin
            min_val = sext32(32'h8000_0000);
            if (is_signed) begin
                a_ext = sext32(dividend[31:0]);
                b_ext = sext32(divisor[31:0]);
            end else begin
                a_ext = {32'b0, dividend[31:0]};
                b_ext = {32'b0, divisor[31:0]};
            end
        end
        a_neg = is_signed && a_ext[63];
        b_neg = is_signed && b_ext[63];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
    end

    always_comb begin
        rem_sh = {rem_p1, quo_p1[63]};
        diff   = rem_sh - {1'b0, den_p1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == DIV_LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo_p1     <= a_mag;
            rem_p1     <= '0;
            den_p1     <= b_mag;
            orig_p1    <= a_ext;
            neg_q_p1   <= a_neg ^ b_neg;
            neg_r_p1   <= a_neg;
            by_zero_p1 <= (b_ext == '0);
            ovf_p1     <= is_signed && (a_ext == min_val) && (b_ext == '1);
        end else if (busy && cnt != DIV_LAST) begin
            if (!diff[64]) begin
                rem_p1 <= diff[63:0];
                quo_p1 <= {quo_p1[62:0], 1'b1};
            end else begin
                rem_p1 <= rem_sh[63:0];
                quo_p1 <= {quo_p1[62:0], 1'b0};
            end
        end
    end

    assign done = busy && (cnt == DIV_LAST);

    always_comb begin
        quotient  = neg_q_p1 ? -quo_p1 : quo_p1;
        remainder = neg_r_p1 ? -rem_p1 : rem_p1;
        if (by_zero_p1) begin
            quotient  = '1;
            remainder = orig_p1;
        end else if (ovf_p1) begin
            quotient  = orig_p1;
            remainder = '0;
        end
    end

endmodule

// File: rtl/alu.sv
// RV64IM execute-stage ALU: combinational integer ops plus a stalling
// multi-cycle engine for M-extension multiply/divide.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    eng_state_t state;
    logic [63:0] l_scr1, l_scr2;
    logic [2:0]  l_func3;
    logic [6:0]  l_opcode;
    logic        l_mul_en;
    logic signed [127:0] prod_p1;
    logic [63:0] div_res;

    logic is_m, same, accept, hold, l_word;
    logic signed [127:0] mul_a, mul_b, mul_prod;
    logic        div_start, div_done, div_signed, div_word;
    logic [63:0] div_quo, div_rem, div_pick, div_sel, eng_out, alu_out;
    logic        taken;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa_w;
    logic [31:0] w32;

    assign is_m   = bus.mul_en && (bus.opcode == OPC_OP || bus.opcode == OPC_OP_32);
    assign same   = (bus.scr1 == l_scr1) && (bus.scr2 == l_scr2) && (bus.func3 == l_func3)
                 && (bus.opcode == l_opcode) && (bus.mul_en == l_mul_en);
    // A DONE cycle whose inputs no longer match behaves exactly like IDLE.
    assign accept = is_m && (state == ST_IDLE || (state == ST_DONE && !same));
    assign hold   = (state == ST_DONE) && same;
    assign l_word = (l_opcode == OPC_OP_32);

    assign div_start  = accept && bus.func3[2];
    assign div_signed = !bus.func3[0];
    assign div_word   = (bus.opcode == OPC_OP_32);

    alu_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .word      (div_word),
        .dividend  (bus.scr1),
        .divisor   (bus.scr2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        mul_a = {{64{l_scr1[63]}}, l_scr1};
        mul_b = {{64{l_scr2[63]}}, l_scr2};
        if (l_func3 == F3_MULHU)
            mul_a = {64'b0, l_scr1};
        if (l_func3 == F3_MULHSU || l_func3 == F3_MULHU)
            mul_b = {64'b0, l_scr2};
        mul_prod = mul_a * mul_b;
    end

    always_comb begin
        div_pick = l_func3[1] ? div_rem : div_quo;
        div_sel  = l_word ? sext32(div_pick[31:0]) : div_pick;
        if (l_func3[2])
            eng_out = div_res;
        else if (l_word)
            eng_out = sext32(prod_p1[31:0]);
        else if (l_func3 == F3_MUL)
            eng_out = prod_p1[63:0];
        else
            eng_out = prod_p1[127:64];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            l_scr1   <= '0;
            l_scr2   <= '0;
            l_func3  <= '0;
            l_opcode <= '0;
            l_mul_en <= 1'b0;
            prod_p1  <= '0;
            div_res  <= '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (!l_func3[2]) begin
                        prod_p1 <= mul_prod;
                        state   <= ST_DONE;
                    end else if (div_done) begin
                        div_res <= div_sel;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        l_scr1   <= bus.scr1;
                        l_scr2   <= bus.scr2;
                        l_func3  <= bus.func3;
                        l_opcode <= bus.opcode;
                        l_mul_en <= bus.mul_en;
                        state    <= ST_BUSY;
                    end else if (!hold) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        sa = bus.scr1;
        sb = bus.scr2;
        case (bus.func3)
            F3_BEQ:  taken = (bus.scr1 == bus.scr2);
            F3_BNE:  taken = (bus.scr1 != bus.scr2);
            F3_BLT:  taken = (sa < sb);
            F3_BGE:  taken = (sa >= sb);
            F3_BLTU: taken = (bus.scr1 < bus.scr2);
            F3_BGEU: taken = (bus.scr1 >= bus.scr2);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_out = '0;
        w32     = '0;
        sa_w    = bus.scr1[31:0];
        case (bus.opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (bus.func3)
                    3'b000: alu_out = (bus.opcode == OPC_OP && bus.func7) ? bus.scr1 - bus.scr2
                                                                            : bus.scr1 + bus.scr2;
                    3'b001: alu_out = bus.scr1 << bus.scr2[5:0];
                    3'b010: alu_out = {63'b0, sa < sb};
                    3'b011: alu_out = {63'b0, bus.scr1 < bus.scr2};
                    3'b100: alu_out = bus.scr1 ^ bus.scr2;
                    3'b101: begin
                        if (bus.func7) alu_out = sa >>> bus.scr2[5:0];
                        else           alu_out = bus.scr1 >> bus.scr2[5:0];
                    end
                    3'b110: alu_out = bus.scr1 | bus.scr2;
                    default: alu_out = bus.scr1 & bus.scr2;
                endcase
            end
            OPC_OP_32, OPC_OP_IMM_32: begin
                case (bus.func3)
                    3'b000: w32 = (bus.opcode == OPC_OP_32 && bus.func7)
                                  ? bus.scr1[31:0] - bus.scr2[31:0]
                                  : bus.scr1[31:0] + bus.scr2[31:0];
                    3'b001: w32 = bus.scr1[31:0] << bus.scr2[4:0];
                    3'b101: begin
                        if (bus.func7) w32 = sa_w >>> bus.scr2[4:0];
                        else           w32 = bus.scr1[31:0] >> bus.scr2[4:0];
                    end
                    default: w32 = '0;
                endcase
                alu_out = sext32(w32);
            end
            OPC_LUI:   alu_out = bus.scr2;
            OPC_AUIPC: alu_out = bus.scr1 + bus.scr2;
            OPC_LOAD, OPC_STORE, OPC_JAL: alu_out = bus.scr1 + bus.imm;
            OPC_JALR:   alu_out = (bus.scr1 + bus.imm) & ~64'd1;
            OPC_BRANCH: alu_out = {63'b0, taken};
            default:    alu_out = '0;
        endcase
    end

    assign bus.stall  = (state == ST_BUSY) || accept;
    assign bus.result = hold ? eng_out : (is_m ? 64'd0 : alu_out);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus random ops compared
// against an arithmetic reference model of the RV64IM rules.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic f7, input logic [63:0] a, b, im);
        logic signed [63:0] sa;
        logic signed [31:0] wa;
        logic [31:0] t;
        sa = a;
        wa = a[31:0];
        case (opc)
            OPC_OP, OPC_OP_IMM: begin
                case (f3)
                    3'd0: return (opc == OPC_OP && f7) ? a - b : a + b;
                    3'd1: return a << b[5:0];
                    3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd3: return (a < b) ? 64'd1 : 64'd0;
                    3'd4: return a ^ b;
                    3'd5: begin
                        if (f7) return sa >>> b[5:0];
                        return a >> b[5:0];
                    end
                    3'd6: return a | b;
                    default: return a & b;
                endcase
            end
            OPC_OP_32, OPC_OP_IMM_32: begin
                t = 32'd0;
                if (f3 == 3'd0) begin
                    if (opc == OPC_OP_32 && f7) t = a[31:0] - b[31:0];
                    else                        t = a[31:0] + b[31:0];
                end else if (f3 == 3'd1) begin
                    t = a[31:0] << b[4:0];
                end else if (f3 == 3'd5) begin
                    if (f7) t = wa >>> b[4:0];
                    else    t = a[31:0] >> b[4:0];
                end
                return sx32(t);
            end
            OPC_LUI:   return b;
            OPC_AUIPC: return a + b;
            OPC_LOAD, OPC_STORE, OPC_JAL: return a + im;
            OPC_JALR:  return (a + im) & ~64'd1;
            OPC_BRANCH: begin
                case (f3)
                    3'd0: return (a == b) ? 64'd1 : 64'd0;
                    3'd1: return (a != b) ? 64'd1 : 64'd0;
                    3'd4: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd5: return ($signed(a) >= $signed(b)) ? 64'd1 : 64'd0;
                    3'd6: return (a < b) ? 64'd1 : 64'd0;
                    3'd7: return (a >= b) ? 64'd1 : 64'd0;
                    default: return 64'd0;
                endcase
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_m(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [63:0] a, b);
        logic signed [127:0] pa, pb, pp;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         ua, ub, t;
        logic [63:0]         r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        if (opc == OPC_OP_32) begin
            t = 32'd0;
            case (f3)
                3'd4: begin
                    if (wb == 0) t = '1;
                    else if (wa == 32'sh8000_0000 && wb == -1) t = wa;
                    else t = wa / wb;
                end
                3'd5: begin
                    if (ub == 0) t = '1;
                    else t = ua / ub;
                end
                3'd6: begin
                    if (wb == 0) t = wa;
                    else if (wa == 32'sh8000_0000 && wb == -1) t = 32'd0;
                    else t = wa % wb;
                end
                3'd7: begin
                    if (ub == 0) t = ua;
                    else t = ua % ub;
                end
                default: t = ua * ub;
            endcase
            return sx32(t);
        end
        r = 64'd0;
        case (f3)
            3'd0: r = a * b;
            3'd1: begin pa = sa; pb = sb; pp = pa * pb; r = pp[127:64]; end
            3'd2: begin pa = sa; pb = {64'b0, b}; pp = pa * pb; r = pp[127:64]; end
            3'd3: begin pa = {64'b0, a}; pb = {64'b0, b}; pp = pa * pb; r = pp[127:64]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a;
                else r = sa / sb;
            end
            3'd5: begin
                if (b == 0) r = '1;
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = 64'd0;
                else r = sa % sb;
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'd1;
            5: return 64'($urandom_range(0, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic men, input logic [63:0] a, b, im);
        bus.opcode = opc;
        bus.func3  = f3;
        bus.func7  = f7;
        bus.mul_en = men;
        bus.scr1   = a;
        bus.scr2   = b;
        bus.imm    = im;
    endtask

    task automatic comb_step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic [63:0] a, b, im, exp);
        @(posedge clk); #1;
        drive(opc, f3, f7, 1'b0, a, b, im);
        @(negedge clk);
        chk({tag, ":res"}, bus.result, exp);
        chk({tag, ":stall"}, {63'b0, bus.stall}, 64'd0);
    endtask

    // Latency counts stalled cycles from first presentation until stall falls.
    task automatic m_step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [63:0] a, b, exp);
        int n;
        logic [63:0] lat_exp;
        @(posedge clk); #1;
        drive(opc, f3, 1'b0, 1'b1, a, b, 64'd0);
        lat_exp = f3[2] ? 64'd66 : 64'd2;
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ":lat"}, 64'(n), lat_exp);
        chk({tag, ":res"}, bus.result, exp);
        @(negedge clk);
        chk({tag, ":hold_res"}, bus.result, exp);
        chk({tag, ":hold_stall"}, {63'b0, bus.stall}, 64'd0);
    endtask

    logic [6:0] opc_tab [13] = '{OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LUI,
                                 OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR,
                                 OPC_BRANCH, OPC_SYSTEM, 7'b1111111};

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [63:0] a, b, im;
        logic [2:0]  w_f3 [3] = '{3'd0, 3'd1, 3'd5};

        rst = 1'b1;
        drive(7'd0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        chk("reset:res", bus.result, 64'd0);
        chk("reset:stall", {63'b0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        comb_step("sub", OPC_OP, 3'd0, 1'b1, 64'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        comb_step("addiw", OPC_OP_IMM_32, 3'd0, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0,
                  64'hFFFF_FFFF_8000_0000);
        comb_step("blt", OPC_BRANCH, F3_BLT, 1'b0, '1, 64'd1, 64'd0, 64'd1);
        comb_step("bltu", OPC_BRANCH, F3_BLTU, 1'b0, '1, 64'd1, 64'd0, 64'd0);
        comb_step("jalr", OPC_JALR, 3'd0, 1'b0, 64'h8000_0003, 64'd0, 64'd4, 64'h8000_0006);
        comb_step("sra", OPC_OP, 3'd5, 1'b1, 64'h8000_0000_0000_0000, 64'd68, 64'd0,
                  64'hF800_0000_0000_0000);
        comb_step("srl", OPC_OP, 3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0,
                  64'h0800_0000_0000_0000);
        comb_step("sraw", OPC_OP_32, 3'd5, 1'b1, 64'h8000_0000, 64'd35, 64'd0,
                  64'hFFFF_FFFF_F000_0000);
        comb_step("system", OPC_SYSTEM, 3'd0, 1'b0, 64'd12, 64'd34, 64'd56, 64'd0);

        for (int i = 0; i < 60; i++) begin
            opc = opc_tab[$urandom_range(0, 12)];
            f3  = 3'($urandom_range(0, 7));
            if (opc == OPC_OP_32 || opc == OPC_OP_IMM_32) f3 = w_f3[$urandom_range(0, 2)];
            f7 = 1'($urandom_range(0, 1));
            a  = pick_op();
            b  = pick_op();
            im = pick_op();
            comb_step($sformatf("rnd_comb%0d", i), opc, f3, f7, a, b, im,
                      ref_alu(opc, f3, f7, a, b, im));
        end

        m_step("mul", OPC_OP, F3_MUL, 64'd3, -64'sd4, 64'hFFFF_FFFF_FFFF_FFF4);
        comb_step("bubble", 7'd0, 3'd0, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0);
        m_step("div0", OPC_OP, F3_DIV, 64'd9, 64'd0, '1);
        m_step("rem0", OPC_OP, F3_REM, 64'd9, 64'd0, 64'd9);
        m_step("divw_ovf", OPC_OP_32, F3_DIV, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
        m_step("div_ovf", OPC_OP, F3_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        m_step("rem_ovf", OPC_OP, F3_REM, 64'h8000_0000_0000_0000, '1, 64'd0);
        m_step("mulhu", OPC_OP, F3_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        m_step("mulh", OPC_OP, F3_MULH, '1, '1, 64'd0);
        m_step("mulhsu", OPC_OP, F3_MULHSU, '1, '1, '1);

        for (int i = 0; i < 16; i++) begin
            opc = ($urandom_range(0, 1) == 0) ? OPC_OP : OPC_OP_32;
            f3  = 3'($urandom_range(0, 7));
            if (opc == OPC_OP_32 && f3 != 3'd0 && !f3[2]) f3 = 3'd0;
            a = pick_op();
            b = pick_op();
            m_step($sformatf("rnd_m%0d", i), opc, f3, a, b, ref_m(opc, f3, a, b));
        end

        // Abort a divide with reset, then rerun the same divide from scratch.
        @(posedge clk); #1;
        drive(OPC_OP, F3_DIVU, 1'b0, 1'b1, 64'd1000, 64'd3, 64'd0);
        repeat (10) @(negedge clk);
        chk("rstdiv:busy", {63'b0, bus.stall}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(OPC_OP, 3'd0, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0);
        #1;
        chk("rstdiv:stall_now", {63'b0, bus.stall}, 64'd0);
        chk("rstdiv:res_now", bus.result, 64'd3);
        @(posedge clk); #1;
        rst = 1'b0;
        m_step("rstdiv_again", OPC_OP, F3_DIVU, 64'd1000, 64'd3, 64'd333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
